// File: rtl/pixel_ram_ctl_if.sv
// Pixel RAM bus between the GPU writer / scan-out reader (master) and pixel_ram_ctl (slave).
interface pixel_ram_ctl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12
);
    logic              clear_req;
    logic              busy;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_add;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_add;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_pix_valid;
    logic              rd_perr;

    // Handshake: requests are single-cycle strobes with no ready; they are taken only while busy=0.
    // Each taken rd_req yields exactly one rd_valid pulse RD_LAT cycles later, in request order.
    modport master (
        output clear_req, wr_req, wr_add, wr_data, rd_req, rd_add,
        input  busy, rd_valid, rd_data, rd_pix_valid, rd_perr
    );
    modport slave (
        input  clear_req, wr_req, wr_add, wr_data, rd_req, rd_add,
        output busy, rd_valid, rd_data, rd_pix_valid, rd_perr
    );
endinterface

// File: rtl/pixel_ram_ctl.sv
// Pixel memory with write port, RD_LAT-stage read pipeline and a fill sweep FSM.
// Optional word parity: define PIXEL_RAM_PARITY_EN.
module pixel_ram_ctl #(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 12,
    parameter int                RD_LAT         = 1,
    parameter logic [DATA_W-1:0] FILL_VAL       = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    pixel_ram_ctl_if.slave bus,
    output logic           fsm_state
);
    localparam int DEPTH = 1 << ADDR_W;
`ifdef PIXEL_RAM_PARITY_EN
    localparam int                 MEM_W     = DATA_W + 1;
    localparam logic [MEM_W-1:0]   FILL_WORD = {^FILL_VAL, FILL_VAL};
`else
    localparam int                 MEM_W     = DATA_W;
    localparam logic [MEM_W-1:0]   FILL_WORD = FILL_VAL;
`endif

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic              wr_en, rd_en;
    logic [MEM_W-1:0]  wr_word, rd_word;
    logic [RD_LAT-1:0] pipe_v;
    logic [MEM_W-1:0]  pipe_w [RD_LAT];

    assign wr_en = (state == READY) && bus.wr_req;
    assign rd_en = (state == READY) && bus.rd_req;

`ifdef PIXEL_RAM_PARITY_EN
    assign wr_word = {^bus.wr_data, bus.wr_data};
`else
    assign wr_word = bus.wr_data;
`endif

    // Write-first: a same-cycle write to the read address is forwarded into the pipeline.
    assign rd_word = (wr_en && (bus.wr_add == bus.rd_add)) ? wr_word : mem[bus.rd_add];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR_ON_RESET ? CLEAR : READY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = READY;
            READY:   if (bus.clear_req) state_nxt = CLEAR;
            default: state_nxt = READY;
        endcase
    end

    always_comb begin
        bus.busy  = (state == CLEAR);
        fsm_state = state;
    end

    // The counter wraps to 0 on its last sweep cycle, so every sweep starts from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              clr_cnt <= '0;
        else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[clr_cnt]    <= FILL_WORD;
        else if (wr_en)     mem[bus.wr_add] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_w[i] <= '0;
        end else begin
            pipe_v[0] <= rd_en;
            if (rd_en) pipe_w[0] <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) pipe_w[i] <= pipe_w[i-1];
            end
        end
    end

    assign bus.rd_valid     = pipe_v[RD_LAT-1];
    assign bus.rd_data      = pipe_w[RD_LAT-1][DATA_W-1:0];
    assign bus.rd_pix_valid = bus.rd_valid && (bus.rd_data != FILL_VAL);
`ifdef PIXEL_RAM_PARITY_EN
    assign bus.rd_perr = bus.rd_valid && (pipe_w[RD_LAT-1][DATA_W] != ^pipe_w[RD_LAT-1][DATA_W-1:0]);
`else
    assign bus.rd_perr = 1'b0;
`endif
endmodule
